sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra SRAM cycles held per half-word access.
REQ-002 SHALL have parameter SRAM_BASE, default 1024: byte address mapped to SRAM half-word 0.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low (rst==0 sampled at a clk edge resets).
REQ-005 SHALL have port wr_en  input  1  store request from MEM stage.
REQ-006 SHALL have port rd_en  input  1  load request from MEM stage.
REQ-007 SHALL have port address  input  32  byte address from ALU result.
REQ-008 SHALL have port write_data  input  32  store data.
REQ-009 SHALL have port read_data  output  32  load data returned to MEM stage.
REQ-010 SHALL have port ready  output  1  0 = freeze pipeline; 1 = access complete or idle.
REQ-011 SHALL have port SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SHALL have port SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 SHALL have ports SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each; all except WE_N tied 0.

Function
REQ-014 SHALL implement FSM states IDLE, ACC_LO, ACC_HI, DONE.
REQ-015 IDLE with (rd_en|wr_en)=1 SHALL go to ACC_LO; otherwise stay IDLE.
REQ-016 ACC_LO and ACC_HI SHALL each last exactly WAIT_STATES+1 cycles, counted by a wait counter cleared on every state entry.
REQ-017 ACC_LO SHALL go to ACC_HI, ACC_HI to DONE, DONE unconditionally to IDLE.
REQ-018 ready SHALL be combinational: 0 when (rd_en|wr_en)=1 and state!=DONE; 1 otherwise.
REQ-019 Latency: with request first seen in IDLE at cycle 0, ready SHALL be 1 in cycle 2*(WAIT_STATES+1)+1 (cycle 5 at default).
REQ-020 Word offset SHALL be (address-SRAM_BASE)>>2, computed modulo 2^32, then truncated; SRAM_ADDR SHALL be {offset[16:0],0} in ACC_LO and {offset[16:0],1} in ACC_HI, 0 otherwise.
REQ-021 For writes, SRAM_WE_N SHALL be 0 throughout ACC_LO/ACC_HI, SRAM_DQ SHALL drive write_data[15:0] in ACC_LO and write_data[31:16] in ACC_HI; else WE_N=1 and DQ high-Z.
REQ-022 For reads, read_data[15:0] SHALL capture SRAM_DQ on the last ACC_LO cycle and read_data[31:16] on the last ACC_HI cycle; read_data SHALL hold until the next read overwrites it.
REQ-023 Operation type SHALL be latched on leaving IDLE; rd_en and wr_en both 1 SHALL be treated as a write.
REQ-024 Deassertion of the request mid-access SHALL NOT abort it; access completes through DONE.
REQ-025 No address range check; out-of-range offsets wrap into SRAM.

Reset
REQ-026 rst==0 SHALL force state IDLE, wait counter 0, read_data 32'h0, SRAM_WE_N 1, SRAM_DQ high-Z, at the next clk edge, including mid-access; the interrupted write is not completed.
REQ-027 Reset SHALL have no effect between clock edges.

Structure
REQ-028 State encoding and SRAM_BASE default SHALL live in the shared package/defines file used by the pipeline stages.
REQ-029 No sub-module SHALL be used; a behavioral sram_model (256K x 16, combinational read) SHALL exist for the bench only.

Verification
REQ-030 Write address=1024, data=32'hDEADBEEF -> SRAM[0]=BEEF, SRAM[1]=DEAD; ready 0 in cycles 0-4, 1 in cycle 5.
REQ-031 Then read address=1024 -> read_data=32'hDEADBEEF in cycle 5, ready=1 in cycle 5.
REQ-032 Write address=1028, data=32'h12345678, then reset (rst=0) in cycle 3 -> SRAM[2]=5678 written, state IDLE, read_data=0, WE_N=1 after edge.
REQ-033 rd_en=wr_en=1, address=1032, data=32'hA5A5_0F0F -> treated as write, SRAM[4]=0F0F, SRAM[5]=A5A5.
REQ-034 No request for 10 cycles -> ready=1, WE_N=1, DQ high-Z, state IDLE throughout.
REQ-035 Back-to-back reads 1024 then 1028 -> second access starts in IDLE the cycle after DONE; each ready pulse one cycle.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller and the pipeline stages that talk to it.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [31:0] SRAM_BASE_DEFAULT = 32'd1024;

  // Word offset wraps modulo 2^32 before truncation, so low addresses alias into the top of SRAM.
  function automatic logic [17:0] half_addr(input logic [31:0] byte_addr,
                                            input logic [31:0] base,
                                            input logic        hi);
    return {17'((byte_addr - base) >> 2), hi};
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses, freezing the pipeline until done.
//
//  state  | meaning
//  IDLE   | no access in flight; latch request, address and data when one arrives
//  ACC_LO | low half-word on the bus for WAIT_STATES+1 cycles
//  ACC_HI | high half-word on the bus for WAIT_STATES+1 cycles
//  DONE   | access complete, ready released for one cycle
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] SRAM_BASE   = SRAM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic        we_n_q, we_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        req;
  logic        last_cycle;

  assign req        = rd_en | wr_en;
  assign last_cycle = (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q + 16'd1;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;

    case (state_q)
      IDLE: begin
        wait_cnt_d = 16'd0;
        if (req) begin
          state_d = ACC_LO;
          op_wr_d = wr_en;
          addr_d  = address;
          wdata_d = write_data;
        end
      end
      ACC_LO: begin
        if (last_cycle) begin
          state_d    = ACC_HI;
          wait_cnt_d = 16'd0;
          if (!op_wr_q) read_data_d[15:0] = SRAM_DQ;
        end
      end
      ACC_HI: begin
        if (last_cycle) begin
          state_d    = DONE;
          wait_cnt_d = 16'd0;
          if (!op_wr_q) read_data_d[31:16] = SRAM_DQ;
        end
      end
      DONE: begin
        state_d    = IDLE;
        wait_cnt_d = 16'd0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 16'd0;
      end
    endcase

    // Bus outputs are registered, so they are derived from the state being entered.
    sram_addr_d = 18'd0;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = 16'd0;
    if (state_d == ACC_LO || state_d == ACC_HI) begin
      sram_addr_d = half_addr(addr_d, SRAM_BASE, state_d == ACC_HI);
      we_n_d      = !op_wr_d;
      dq_oe_d     = op_wr_d;
      dq_out_d    = (state_d == ACC_HI) ? wdata_d[31:16] : wdata_d[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 16'd0;
      op_wr_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      sram_addr_q <= 18'd0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign read_data = read_data_q;
  assign ready     = !(req && (state_q != DONE));

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller against an in-bench 256K x 16 SRAM model with combinational read.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         we_n, ub_n, lb_n, ce_n, oe_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          exp_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sram_model: asynchronous SRAM behaviour, write sampled at each clock while WE_N is low
  logic [15:0] mem [0:262143];
  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!we_n) mem[sram_addr] <= sram_dq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every completed access (request held and ready high) pops one expectation.
  always @(negedge clk) begin
    if (rst && (rd_en || wr_en) && ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0 cycle=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_ready_cycle"}, 32'(cyc), 32'(e.exp_cyc));
        check({e.name, "_read_data"}, read_data, e.data);
      end
    end
  end

  // Call at posedge+#1 with the controller idle; returns at posedge+#1 after the DONE cycle.
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input bit hold);
    exp_t e;
    bit   got;
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    write_data = d;
    e.data     = exp_rd;
    e.exp_cyc  = cyc + 5;
    e.name     = name;
    sb.push_back(e);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ready required=ready_within_20", name);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      rd_en = 0;
      wr_en = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_read_data", read_data, 32'd0);
    check("reset_we_n", {31'd0, we_n}, 32'd1);
    check("reset_sram_addr", {14'd0, sram_addr}, 32'd0);
    check("tie_offs", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1;

    do_access("wr_1024", 0, 1, 32'd1024, 32'hDEADBEEF, 32'd0, 0);
    check("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check("mem1", {16'd0, mem[1]}, 32'h0000DEAD);

    do_access("rd_1024", 1, 0, 32'd1024, 32'd0, 32'hDEADBEEF, 0);

    do_access("wr_1028", 0, 1, 32'd1028, 32'hCAFEF00D, 32'hDEADBEEF, 0);
    check("mem2", {16'd0, mem[2]}, 32'h0000F00D);
    check("mem3", {16'd0, mem[3]}, 32'h0000CAFE);

    // Reset asserted in cycle 3 of a write; wr_en drops with it.
    wr_en = 1;
    address = 32'd1028;
    write_data = 32'h12345678;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 0;
    wr_en = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_read_data", read_data, 32'd0);
    check("midrst_we_n", {31'd0, we_n}, 32'd1);
    check("midrst_sram_addr", {14'd0, sram_addr}, 32'd0);
    check("midrst_mem2", {16'd0, mem[2]}, 32'h00005678);
    @(negedge clk);
    check("midrst_hold_we_n", {31'd0, we_n}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1;

    do_access("rdwr_1032", 1, 1, 32'd1032, 32'hA5A50F0F, 32'd0, 0);
    check("mem4", {16'd0, mem[4]}, 32'h00000F0F);
    check("mem5", {16'd0, mem[5]}, 32'h0000A5A5);

    // Request withdrawn after one cycle must still complete.
    wr_en = 1;
    address = 32'd1040;
    write_data = 32'h11112222;
    @(posedge clk);
    #1;
    wr_en = 0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_mem8", {16'd0, mem[8]}, 32'h00002222);
    check("abort_mem9", {16'd0, mem[9]}, 32'h00001111);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, we_n}, 32'd1);
      check("idle_sram_addr", {14'd0, sram_addr}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Address 0 sits below SRAM_BASE and wraps to half-words 0x3FE00/0x3FE01.
    do_access("wr_wrap", 0, 1, 32'd0, 32'h0BADC0DE, 32'd0, 0);
    check("mem_wrap_lo", {16'd0, mem[18'h3FE00]}, 32'h0000C0DE);
    check("mem_wrap_hi", {16'd0, mem[18'h3FE01]}, 32'h00000BAD);
    do_access("rd_wrap", 1, 0, 32'd0, 32'd0, 32'h0BADC0DE, 0);

    do_access("wr_1028b", 0, 1, 32'd1028, 32'hCAFEF00D, 32'h0BADC0DE, 0);
    do_access("b2b_rd_1024", 1, 0, 32'd1024, 32'd0, 32'hDEADBEEF, 1);
    do_access("b2b_rd_1028", 1, 0, 32'd1028, 32'd0, 32'hCAFEF00D, 0);

    @(negedge clk);
    check("final_read_data_hold", read_data, 32'hCAFEF00D);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
